// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and constants for the frame buffer controller.
// Geometry comes from the DISPLAY_WIDTH / DISPLAY_HEIGHT / H_BITS / V_BITS / COLOR_BITS
// macros. Each macro falls back to 320x240, 10-bit counters and 4-bit colour when it is not
// given on the command line.
// Optional feature macro: DOUBLE_BUFFER_EN (see frame_buffer_ctrl.sv).
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 10
`endif
`ifndef V_BITS
`define V_BITS 10
`endif
`ifndef COLOR_BITS
`define COLOR_BITS 4
`endif
`ifndef FB_ADDR_BITS
`define FB_ADDR_BITS $clog2(`DISPLAY_WIDTH*`DISPLAY_HEIGHT)
`endif

package frame_buffer_ctrl_pkg;
  localparam int DISPLAY_WIDTH   = `DISPLAY_WIDTH;
  localparam int DISPLAY_HEIGHT  = `DISPLAY_HEIGHT;
  localparam int H_BITS          = `H_BITS;
  localparam int V_BITS          = `V_BITS;
  localparam int COLOR_BITS      = `COLOR_BITS;
  localparam int FB_DEPTH        = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int FB_ADDR_BITS    = `FB_ADDR_BITS;
  localparam int FB_READ_LATENCY = 2;

  typedef logic [FB_ADDR_BITS-1:0] fb_addr_t;

  // Bounds in the counter widths, so range checks compare equal-width operands.
  localparam logic [H_BITS-1:0] DISP_W_H = H_BITS'(DISPLAY_WIDTH);
  localparam logic [V_BITS-1:0] DISP_H_V = V_BITS'(DISPLAY_HEIGHT);

  // Render-side frame tracking: the first new_frame only arms it.
  typedef enum logic {TRK_IDLE, TRK_ARMED} trk_state_t;

  // Linear pixel address: v*W + h.
  function automatic fb_addr_t fb_addr(input logic [H_BITS-1:0] h, input logic [V_BITS-1:0] v);
    return fb_addr_t'(int'(v) * DISPLAY_WIDTH + int'(h));
  endfunction
endpackage

// File: rtl/frame_buffer_ctrl_fb_bank_ram.sv
// fb_bank_ram: simple dual-port frame memory bank.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr in, rd_data registered out.
// Read-first: a same-edge write and read to one address returns the previous contents.
// Contents are never cleared.
module fb_bank_ram
  import frame_buffer_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  fb_addr_t              wr_addr,
  input  logic [COLOR_BITS-1:0] wr_data,
  input  fb_addr_t              rd_addr,
  output logic [COLOR_BITS-1:0] rd_data
);
  logic [COLOR_BITS-1:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: stores the ray_marcher pixel stream and serves display reads.
// Ports:
//   clk_in, rst_in (async, active-high)
//   wr_hcount_in/wr_vcount_in/wr_color_in/wr_valid_in: render write, no backpressure
//   new_frame_in: render side started a new frame
//   disp_hcount_in/disp_vcount_in: display timing position (blanking included)
//   disp_color_out/disp_valid_out: pixel colour 2 cycles after the disp_* inputs
//   front_bank_out: displayed bank; frame_count_out: number of flips shown
//   wr_drop_out: sticky flag for a discarded out-of-range write
// Macro DOUBLE_BUFFER_EN: two banks, rendering into the back bank, with the flip at the
// first cycle of display vblank. Without it one bank is shared and front_bank_out is 0.
module frame_buffer_ctrl
  import frame_buffer_ctrl_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     wr_hcount_in,
  input  logic [V_BITS-1:0]     wr_vcount_in,
  input  logic [COLOR_BITS-1:0] wr_color_in,
  input  logic                  wr_valid_in,
  input  logic                  new_frame_in,
  input  logic [H_BITS-1:0]     disp_hcount_in,
  input  logic [V_BITS-1:0]     disp_vcount_in,
  output logic [COLOR_BITS-1:0] disp_color_out,
  output logic                  disp_valid_out,
  output logic                  front_bank_out,
  output logic [15:0]           frame_count_out,
  output logic                  wr_drop_out
);
  logic                  wr_in_range;
  logic                  wr_en_q;
  fb_addr_t              wr_addr_q;
  logic [COLOR_BITS-1:0] wr_color_q;
  logic                  disp_active;
  fb_addr_t              rd_addr_q;
  logic [FB_READ_LATENCY-1:0] act_pipe;
  logic [COLOR_BITS-1:0] rd_color;
  logic                  flip_event;
  logic                  flip_pending;
  trk_state_t            trk_state;
  logic [15:0]           frame_count;

  assign wr_in_range = (wr_hcount_in < DISP_W_H) && (wr_vcount_in < DISP_H_V);
  assign disp_active = (disp_hcount_in < DISP_W_H) && (disp_vcount_in < DISP_H_V);
  assign flip_event  = flip_pending && (disp_hcount_in == '0) && (disp_vcount_in == DISP_H_V);

`ifdef DOUBLE_BUFFER_EN
  logic                  write_bank;
  logic                  completed_bank;
  logic                  front_bank;
  logic                  wr_bank_q;
  logic                  rd_bank_q1;
  logic                  rd_bank_q2;
  logic [COLOR_BITS-1:0] rd_data0;
  logic [COLOR_BITS-1:0] rd_data1;
`endif

  // Write stage: address computed and registered; the RAM write happens on the next edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_color_q  <= '0;
      wr_drop_out <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
      wr_bank_q   <= 1'b0;
`endif
    end else begin
      wr_en_q <= wr_valid_in && wr_in_range;
      if (wr_valid_in && wr_in_range) begin
        wr_addr_q  <= fb_addr(wr_hcount_in, wr_vcount_in);
        wr_color_q <= wr_color_in;
`ifdef DOUBLE_BUFFER_EN
        wr_bank_q  <= write_bank;
`endif
      end
      if (wr_valid_in && !wr_in_range) wr_drop_out <= 1'b1;
    end
  end

  // Read stage 1: address register plus the active-pixel pipeline.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_addr_q <= '0;
      act_pipe  <= '0;
`ifdef DOUBLE_BUFFER_EN
      rd_bank_q1 <= 1'b0;
      rd_bank_q2 <= 1'b0;
`endif
    end else begin
      // Blanking positions read address 0 so the RAM index always stays in range.
      rd_addr_q <= disp_active ? fb_addr(disp_hcount_in, disp_vcount_in) : '0;
      act_pipe  <= {act_pipe[FB_READ_LATENCY-2:0], disp_active};
`ifdef DOUBLE_BUFFER_EN
      // The bank select follows the read through both stages so the mux matches the data.
      rd_bank_q1 <= front_bank;
      rd_bank_q2 <= rd_bank_q1;
`endif
    end
  end

  // Bank / frame tracking. When new_frame coincides with a flip, the flip still takes the
  // old completed_bank, and the later assignment keeps flip_pending set for the next vblank.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      trk_state      <= TRK_IDLE;
      flip_pending   <= 1'b0;
      frame_count    <= '0;
`ifdef DOUBLE_BUFFER_EN
      write_bank     <= 1'b0;
      completed_bank <= 1'b0;
      front_bank     <= 1'b0;
`endif
    end else begin
      if (flip_event) begin
        flip_pending <= 1'b0;
        frame_count  <= frame_count + 16'd1;
`ifdef DOUBLE_BUFFER_EN
        front_bank   <= completed_bank;
`endif
      end
      if (new_frame_in) begin
        if (trk_state == TRK_IDLE) begin
          trk_state <= TRK_ARMED;
        end else begin
          flip_pending   <= 1'b1;
`ifdef DOUBLE_BUFFER_EN
          completed_bank <= write_bank;
          write_bank     <= ~write_bank;
`endif
        end
      end
    end
  end

`ifdef DOUBLE_BUFFER_EN
  fb_bank_ram u_bank0 (
    .clk(clk_in), .we(wr_en_q && !wr_bank_q), .wr_addr(wr_addr_q), .wr_data(wr_color_q),
    .rd_addr(rd_addr_q), .rd_data(rd_data0)
  );
  fb_bank_ram u_bank1 (
    .clk(clk_in), .we(wr_en_q && wr_bank_q), .wr_addr(wr_addr_q), .wr_data(wr_color_q),
    .rd_addr(rd_addr_q), .rd_data(rd_data1)
  );
  assign rd_color       = rd_bank_q2 ? rd_data1 : rd_data0;
  assign front_bank_out = front_bank;
`else
  fb_bank_ram u_bank0 (
    .clk(clk_in), .we(wr_en_q), .wr_addr(wr_addr_q), .wr_data(wr_color_q),
    .rd_addr(rd_addr_q), .rd_data(rd_color)
  );
  assign front_bank_out = 1'b0;
`endif

  assign disp_valid_out  = act_pipe[FB_READ_LATENCY-1];
  assign disp_color_out  = disp_valid_out ? rd_color : '0;
  assign frame_count_out = frame_count;
endmodule
